pnser_sched: RTL and testbench

//  Round-robin scheduler sharing one pnser serializer between N requesters.

---
 rtl/pnser_sched_if.sv | 27 ++
 rtl/pnser_sched.sv | 156 +++++++++++++++
 tb/tb_pnser_sched.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pnser_sched_if.sv
// Bundle of the requester-side and serializer-side signals of pnser_sched.
// The scheduler sits on the slave modport; clients plus the pnser drive the master side.
interface pnser_sched_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_i;
  logic [32*N-1:0] dat_i;
  logic [5*N-1:0] len_i;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   done_o;
  logic           err_o;
  logic           busy_o;
  logic [31:0]    ser_rnd_o;
  logic [4:0]     ser_len_o;
  logic           ser_rst_o;
  logic           ser_ack_i;

  modport slave (
    input  req_i, dat_i, len_i, ser_ack_i,
    output gnt_o, done_o, err_o, busy_o, ser_rnd_o, ser_len_o, ser_rst_o
  );

  modport master (
    output req_i, dat_i, len_i, ser_ack_i,
    input  gnt_o, done_o, err_o, busy_o, ser_rnd_o, ser_len_o, ser_rst_o
  );
endinterface

// File: rtl/pnser_sched.sv
// Round-robin scheduler that time-shares one pnser serializer between N clients.
// A job captures the owner's word/length, holds the serializer in reset briefly,
// releases it, waits for ack (or times out) and pulses done/err back to the owner.
module pnser_sched #(
  parameter int N       = 4,
  parameter int RST_CYC = 2,
  parameter int TO_CYC  = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  pnser_sched_if.slave bus
);

  localparam int PW  = (N > 1) ? $clog2(N) : 1;
  localparam int NP  = 2 ** PW;
  localparam int CW  = $clog2(TO_CYC);
  localparam int LCW = (RST_CYC > 0) ? $clog2(RST_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [N-1:0]    gnt_reg;
  logic [N-1:0]    done_reg;
  logic            err_reg;
  logic [31:0]     rnd_reg;
  logic [4:0]      len_reg;
  logic            ser_rst_reg;
  logic [CW-1:0]   cnt_reg;
  logic [LCW-1:0]  ld_cnt_reg;

  // Per-requester views of the packed word/length buses, padded to a power of two
  // so the winner index can never select outside the array.
  logic [31:0] dat_arr [NP];
  logic [4:0]  len_arr [NP];

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_slice
      if (gi < N) begin : g_real
        assign dat_arr[gi] = bus.dat_i[32*gi +: 32];
        assign len_arr[gi] = bus.len_i[5*gi +: 5];
      end else begin : g_pad
        assign dat_arr[gi] = '0;
        assign len_arr[gi] = '0;
      end
    end
  endgenerate

  logic [PW-1:0] win_idx;
  logic [N-1:0]  win_oh;
  logic [31:0]   win_dat;
  logic [4:0]    win_len;
  logic          any_req;

  // Round-robin pick: scan downward so the last hit is the first set bit after ptr.
  always_comb begin
    int k;
    logic [PW-1:0] kk;
    k       = 0;
    kk      = '0;
    win_idx = '0;
    for (int i = N; i >= 1; i--) begin
      k = int'(ptr_reg) + i;
      if (k >= N) k = k - N;
      kk = PW'(k);
      if (bus.req_i[kk]) win_idx = kk;
    end
  end

  assign any_req = |bus.req_i;
  assign win_oh  = N'(1) << win_idx;
  assign win_dat = dat_arr[win_idx];
  assign win_len = len_arr[win_idx];

  // Job sequencer: all outputs are registered and change on state transitions.
  // The grant cycle lets the captured word settle before the RST_CYC strobe cycles,
  // so the serializer leaves reset 1+RST_CYC cycles after gnt_o rises.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      ptr_reg     <= PW'(N - 1);
      gnt_reg     <= '0;
      done_reg    <= '0;
      err_reg     <= 1'b0;
      rnd_reg     <= '0;
      len_reg     <= '0;
      ser_rst_reg <= 1'b1;
      cnt_reg     <= '0;
      ld_cnt_reg  <= '0;
    end else begin
      done_reg <= '0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            gnt_reg    <= win_oh;
            rnd_reg    <= win_dat;
            len_reg    <= win_len;
            ptr_reg    <= win_idx;
            ld_cnt_reg <= '0;
            cnt_reg    <= '0;
            if (win_len == 5'd0) begin
              // Nothing to serialize: skip straight to an error completion.
              state_reg <= DONE;
              done_reg  <= win_oh;
              err_reg   <= 1'b1;
            end else begin
              state_reg <= LOAD;
            end
          end
        end
        LOAD: begin
          if (ld_cnt_reg == LCW'(RST_CYC)) begin
            state_reg   <= RUN;
            ser_rst_reg <= 1'b0;
          end else begin
            ld_cnt_reg <= ld_cnt_reg + 1'b1;
          end
        end
        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (bus.ser_ack_i) begin
            state_reg   <= DONE;
            done_reg    <= gnt_reg;
            ser_rst_reg <= 1'b1;
          end else if (cnt_reg == CW'(TO_CYC - 1)) begin
            state_reg   <= DONE;
            done_reg    <= gnt_reg;
            err_reg     <= 1'b1;
            ser_rst_reg <= 1'b1;
          end
        end
        DONE: begin
          gnt_reg   <= '0;
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg   <= IDLE;
          gnt_reg     <= '0;
          ser_rst_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.gnt_o     = gnt_reg;
  assign bus.done_o    = done_reg;
  assign bus.err_o     = err_reg;
  assign bus.busy_o    = (state_reg != IDLE);
  assign bus.ser_rnd_o = rnd_reg;
  assign bus.ser_len_o = len_reg;
  assign bus.ser_rst_o = ser_rst_reg;

endmodule

// File: tb/tb_pnser_sched.sv
// Directed bench for pnser_sched: a small pnser stand-in answers with ack, a monitor
// pops expected grants/completions from scoreboard queues and checks them.
module tb_pnser_sched;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pnser_sched_if #(.N(N)) bus ();

  pnser_sched #(.N(N), .RST_CYC(2), .TO_CYC(64)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboards: grants in expected order, completions as {one-hot owner, err}.
  logic [N-1:0] gnt_q  [$];
  logic [N:0]   done_q [$];

  // Requester k asks while it has been served fewer jobs than wanted.
  int want   [N];
  int served [N];
  logic [N-1:0] req_vec;
  always_comb begin
    req_vec = '0;
    for (int k = 0; k < N; k++) req_vec[k] = (served[k] < want[k]);
  end
  assign bus.req_i = req_vec;

  logic ack_en  = 1'b1;
  int   run_cnt = 0;
  int   ack_cyc = 0;
  int   low_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pnser stand-in: acks once len cycles after it leaves reset.
  initial begin
    bus.ser_ack_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ser_rst_o) begin
        run_cnt       = 0;
        bus.ser_ack_i = 1'b0;
      end else begin
        run_cnt++;
        bus.ser_ack_i = ack_en && (run_cnt == int'(bus.ser_len_o));
        if (bus.ser_ack_i) ack_cyc = cyc;
      end
    end
  end

  // Monitor: one line per grant and per completion.
  initial begin
    logic [N-1:0] prev_gnt;
    logic [N-1:0] eg;
    logic [N:0]   ed;
    prev_gnt = '0;
    for (int k = 0; k < N; k++) served[k] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_gnt = '0;
      end else begin
        if (!bus.ser_rst_o) low_cnt++;
        if (bus.gnt_o != '0 && prev_gnt == '0) begin
          $display("[%0d] grant gnt=%b dat=%h len=%0d", cyc, bus.gnt_o, bus.ser_rnd_o, bus.ser_len_o);
          if (gnt_q.size() == 0) begin
            chk("gnt_unexpected", 64'(bus.gnt_o), 64'(0));
          end else begin
            eg = gnt_q.pop_front();
            chk("gnt_order", 64'(bus.gnt_o), 64'(eg));
          end
        end
        prev_gnt = bus.gnt_o;
        if (bus.done_o != '0) begin
          $display("[%0d] done done=%b err=%b", cyc, bus.done_o, bus.err_o);
          if (done_q.size() == 0) begin
            chk("done_unexpected", 64'(bus.done_o), 64'(0));
          end else begin
            ed = done_q.pop_front();
            chk("done_idx", 64'(bus.done_o), 64'(ed[N:1]));
            chk("done_err", 64'(bus.err_o), 64'(ed[0]));
            chk("done_gnt_held", 64'(bus.gnt_o), 64'(ed[N:1]));
            if (!ed[0]) chk("ack_to_done", 64'(cyc - ack_cyc), 64'(1));
          end
          for (int k = 0; k < N; k++) if (bus.done_o[k]) served[k]++;
        end else if (bus.err_o) begin
          chk("err_without_done", 64'(bus.err_o), 64'(0));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !(gnt_q.size() == 0 && done_q.size() == 0 &&
                           !bus.busy_o && bus.req_i == '0)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drained"}, 64'(gnt_q.size() + done_q.size()), 64'(0));
    chk({tag, "_idle"}, 64'(bus.busy_o), 64'(0));
  endtask

  task automatic set_job(input int k, input logic [31:0] d, input logic [4:0] l);
    bus.dat_i[32*k +: 32] = d;
    bus.len_i[5*k +: 5]   = l;
  endtask

  initial begin
    int n;
    int base;
    for (int k = 0; k < N; k++) want[k] = 0;
    bus.dat_i = '0;
    bus.len_i = '0;

    // Reset values
    do_reset();
    chk("rst_gnt", 64'(bus.gnt_o), 64'(0));
    chk("rst_done", 64'(bus.done_o), 64'(0));
    chk("rst_err", 64'(bus.err_o), 64'(0));
    chk("rst_busy", 64'(bus.busy_o), 64'(0));
    chk("rst_rnd", 64'(bus.ser_rnd_o), 64'(0));
    chk("rst_len", 64'(bus.ser_len_o), 64'(0));
    chk("rst_ser_rst", 64'(bus.ser_rst_o), 64'(1));

    // 1: single job with ack; later dat/len changes must be ignored
    set_job(0, 32'hAB, 5'd8);
    gnt_q.push_back(4'b0001);
    done_q.push_back({4'b0001, 1'b0});
    want[0] = served[0] + 1;
    n = 0;
    while (n < 20 && bus.gnt_o == '0) begin
      @(negedge clk);
      n++;
    end
    chk("t1_gnt", 64'(bus.gnt_o), 64'(4'b0001));
    chk("t1_rnd", 64'(bus.ser_rnd_o), 64'(32'hAB));
    chk("t1_len", 64'(bus.ser_len_o), 64'(8));
    chk("t1_busy", 64'(bus.busy_o), 64'(1));
    set_job(0, 32'h55, 5'd3);
    n = 0;
    while (n < 10 && bus.ser_rst_o) begin
      @(negedge clk);
      n++;
    end
    chk("t1_rst_latency", 64'(n), 64'(3));
    chk("t1_rnd_held", 64'(bus.ser_rnd_o), 64'(32'hAB));
    wait_idle("t1", 100);

    // 2: all four requesting, round-robin from a fresh pointer
    do_reset();
    for (int k = 0; k < N; k++) set_job(k, 32'h1111 * (k + 1), 5'd4);
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010); gnt_q.push_back(4'b0100);
    gnt_q.push_back(4'b1000); gnt_q.push_back(4'b0001);
    done_q.push_back({4'b0001, 1'b0}); done_q.push_back({4'b0010, 1'b0});
    done_q.push_back({4'b0100, 1'b0}); done_q.push_back({4'b1000, 1'b0});
    done_q.push_back({4'b0001, 1'b0});
    want[0] = served[0] + 2;
    want[1] = served[1] + 1;
    want[2] = served[2] + 1;
    want[3] = served[3] + 1;
    wait_idle("t2", 300);

    // 3: after serving 0, requester 1 wins over 0
    do_reset();
    gnt_q.push_back(4'b0001);
    done_q.push_back({4'b0001, 1'b0});
    want[0] = served[0] + 1;
    wait_idle("t3a", 100);
    gnt_q.push_back(4'b0010); gnt_q.push_back(4'b0001);
    done_q.push_back({4'b0010, 1'b0}); done_q.push_back({4'b0001, 1'b0});
    want[0] = served[0] + 1;
    want[1] = served[1] + 1;
    wait_idle("t3b", 200);

    // 4: zero length is skipped with err, serializer stays in reset
    do_reset();
    set_job(2, 32'hDEAD, 5'd0);
    base = low_cnt;
    gnt_q.push_back(4'b0100);
    done_q.push_back({4'b0100, 1'b1});
    want[2] = served[2] + 1;
    wait_idle("t4", 50);
    chk("t4_rst_never_low", 64'(low_cnt - base), 64'(0));

    // 5: no ack: each job aborts after 64 RUN cycles, next requester still served
    do_reset();
    ack_en = 1'b0;
    set_job(0, 32'hC0FFEE, 5'd12);
    set_job(1, 32'h1234, 5'd4);
    base = low_cnt;
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0010);
    done_q.push_back({4'b0001, 1'b1}); done_q.push_back({4'b0010, 1'b1});
    want[0] = served[0] + 1;
    want[1] = served[1] + 1;
    wait_idle("t5", 400);
    chk("t5_run_cycles", 64'(low_cnt - base), 64'(128));
    ack_en = 1'b1;

    // 6: reset in RUN kills the job silently; the pending request is regranted
    do_reset();
    set_job(0, 32'hFACE, 5'd20);
    gnt_q.push_back(4'b0001);
    want[0] = served[0] + 1;
    n = 0;
    while (n < 20 && bus.ser_rst_o) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_run", 64'(bus.ser_rst_o), 64'(0));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_gnt", 64'(bus.gnt_o), 64'(0));
    chk("t6_ser_rst", 64'(bus.ser_rst_o), 64'(1));
    chk("t6_done", 64'(bus.done_o), 64'(0));
    chk("t6_busy", 64'(bus.busy_o), 64'(0));
    gnt_q.push_back(4'b0001);
    done_q.push_back({4'b0001, 1'b0});
    rst = 1'b0;
    wait_idle("t6", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
